booth2_seq_mult: RTL and testbench
==================================

# booth2_seq_mult

Iterative unsigned radix-4 Booth multiplier front end. It sits directly upstream of the radix-4 Booth select stage. Each cycle it recodes one overlapping bit-triple of the multiplier into the select controls (M1, M2, S), forms the selected and conditionally inverted partial product, and accumulates it at the correct weight. After W/2+1 digit cycles it presents a 2W-bit unsigned product under a start/busy/done handshake.

## Interface
Parameters:
- W, default 4: operand width in bits. Must be even and ≥2.
- D, derived as W/2+1: number of Booth digits (the extra digit covers unsigned operands).

Ports:
- clk, input, 1: rising-edge clock.
- reset_b, input, 1: asynchronous, active-low reset.
- start, input, 1: request a multiply. Sampled only in IDLE.
- a, input, W: multiplier, unsigned. Captured on the accepted start.
- b, input, W: multiplicand, unsigned. Captured on the accepted start.
- busy, output, 1: high while digits are being processed (RUN).
- done, output, 1: one-cycle pulse; p is valid while done is high.
- p, output, 2W: product. Held until the next accepted start.
- sel_m1, output, 1: current digit selects 1×b.
- sel_m2, output, 1: current digit selects 2×b.
- sel_s, output, 1: current digit is negative (invert and add 1).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1: latch a zero-extended to W+2 bits with an implicit a[-1]=0, latch b, clear the accumulator, clear digit counter i.
  - RUN: one digit per cycle; i increments. On the edge that processes digit D-1 the FSM goes to DONE.
  - DONE → IDLE unconditionally after one cycle.
- Digit i uses the triple t = {a[2i+1], a[2i], a[2i-1]}.
- Recoding of t to (M1, M2, S) and digit value:
  - 000 → (0,0,0), digit 0
  - 001 → (1,0,0), digit +1
  - 010 → (1,0,0), digit +1
  - 011 → (0,1,0), digit +2
  - 100 → (0,1,1), digit −2
  - 101 → (1,0,1), digit −1
  - 110 → (1,0,1), digit −1
  - 111 → (0,0,1), digit 0 (S=1 with zero selection is legal: all-ones plus 1 gives 0)
- Partial product: w = M2 ? {b,0} : (M1 ? {0,b} : 0), W+1 bits. pp = w XOR {W+1{S}}.
- pp is extended with S to 2W+2 bits, shifted left by 2i, and added to the accumulator. S is injected as the carry-in at bit 2i. All arithmetic is modulo 2^(2W+2).
- p is the low 2W bits of the accumulator, registered on the DONE entry edge. The true product always fits in 2W bits.
- sel_m1, sel_m2, sel_s show the recoding of the digit being processed in RUN, and are 0 in IDLE and DONE.
- start while busy, or in the DONE cycle, is ignored. The operands in flight are unaffected.
- Changes on a or b after capture have no effect.

## Timing
- Reset values (asynchronous, while reset_b=0): state IDLE, busy=0, done=0, p=0, sel_*=0, accumulator=0, i=0.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and p reads 0 after reset.
- Start accepted at edge k:
  - busy=1 from edge k to edge k+D.
  - Digit i is accumulated at edge k+1+i. sel_* show digit i during the cycle before that edge.
  - done=1 and the new p are present from edge k+D to edge k+D+1.
- Earliest next accept is edge k+D+2, giving a throughput of one multiply per D+2 cycles.
- done and busy are never high together.

## Test plan
- W=4, a=15, b=15, start: sel trace (M1,M2,S) = (1,0,1), (0,0,1), (1,0,0); done 3 cycles after accept; p=225.
- W=4, a=6, b=11: digits −2, +2, 0; p=66. Also a=0, b=13 gives p=0 with every digit 0.
- W=4, start held high continuously, with a/b changed every cycle: only the captured pair multiplies; the next accept is 2 cycles after done; p of each result matches its captured pair.
- Reset_b pulsed low during the 2nd RUN cycle: outputs go to 0 immediately, no done pulse; a following 9×7 gives p=63.
- W=8, exhaustive or random a,b (including 255×255=65025 and 128×2=256): p=a·b, done exactly 5 cycles after accept.

Source files
------------

// File: rtl/booth2_seq_mult.sv
// booth2_seq_mult: iterative unsigned radix-4 Booth multiplier, one recoded digit per cycle.
module booth2_seq_mult #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p,
  output logic           sel_m1,
  output logic           sel_m2,
  output logic           sel_s
);
  localparam int D  = W / 2 + 1;
  localparam int IW = $clog2(D + 1);
  localparam logic [IW-1:0] LAST = IW'(D - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t         r_state, w_state_nxt;
  logic [W+2:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc, r_p, w_sum, w_ext, w_cin;
  logic [IW-1:0]  r_i;
  logic [2:0]     w_t;
  logic [W:0]     w_w, w_pp;
  logic           w_run;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = (r_state == S_IDLE) ? (start ? S_RUN : S_IDLE) :
                  (r_state == S_RUN) ? ((r_i == LAST) ? S_DONE : S_RUN) : S_IDLE;
    w_run  = r_state == S_RUN;
    w_t    = r_a[2:0];
    sel_m1 = w_run & (w_t[0] ^ w_t[1]);
    sel_m2 = w_run & ((w_t == 3'b011) | (w_t == 3'b100));
    sel_s  = w_run & w_t[2];
    busy   = w_run;
    done   = r_state == S_DONE;
    w_w    = sel_m2 ? {r_b, 1'b0} : (sel_m1 ? {1'b0, r_b} : '0);
    w_pp   = w_w ^ {(W + 1){sel_s}};
    // The low 2W bits of the modular sum are all that p ever needs.
    w_ext  = {{(W - 1){sel_s}}, w_pp};
    w_cin  = {{(2 * W - 1){1'b0}}, sel_s};
    w_sum  = r_acc + (w_ext << {r_i, 1'b0}) + (w_cin << {r_i, 1'b0});
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_p   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_a   <= {2'b00, a, 1'b0};
      r_b   <= b;
      r_acc <= '0;
      r_i   <= '0;
    end else if (w_run) begin
      r_a   <= r_a >> 2;
      r_acc <= w_sum;
      r_i   <= r_i + IW'(1);
      if (r_i == LAST) r_p <= w_sum;
    end
  assign p = r_p;
endmodule

// File: tb/tb_booth2_seq_mult.sv
// tb_booth2_seq_mult: W=4 and W=8 instances checked each cycle against a behavioural model.
module tb_booth2_seq_mult;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic [1:0] st = '0;
  logic [1:0][7:0] ia = '0, ib = '0;
  logic [1:0][15:0] op;
  logic [1:0] ob, od, om1, om2, os;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int WG = (g == 0) ? 4 : 8;
    localparam int DG = WG / 2 + 1;
    logic [2*WG-1:0] pl;
    int ph = -1, ea = 0, eb = 0, ep = 0;
    booth2_seq_mult #(.W(WG)) dut (
      .clk(clk), .reset_b(reset_b), .start(st[g]),
      .a(ia[g][WG-1:0]), .b(ib[g][WG-1:0]),
      .busy(ob[g]), .done(od[g]), .p(pl),
      .sel_m1(om1[g]), .sel_m2(om2[g]), .sel_s(os[g])
    );
    assign op[g] = 16'(pl);
    // ph: -1 idle, 0..DG-1 digit being processed, DG the done cycle
    always @(posedge clk or negedge reset_b)
      if (!reset_b) begin
        ph = -1;
        ep = 0;
      end else if (ph == -1) begin
        if (st[g]) begin
          ea = int'(ia[g][WG-1:0]);
          eb = int'(ib[g][WG-1:0]);
          ph = 0;
        end
      end else if (ph < DG - 1) ph++;
      else if (ph == DG - 1) begin
        ph = DG;
        ep = ea * eb;
      end else ph = -1;
    always @(negedge clk) begin
      int t, dv, bz, es;
      bz = (ph >= 0 && ph < DG) ? 1 : 0;
      es = 0;
      if (bz == 1) begin
        t  = ((ea * 2) >> (2 * ph)) & 7;
        dv = (t & 1) + ((t >> 1) & 1) - 2 * ((t >> 2) & 1);
        es = ((dv == 1 || dv == -1) ? 4 : 0) + ((dv == 2 || dv == -2) ? 2 : 0) + ((t >> 2) & 1);
      end
      chk($sformatf("busy%0d", WG), ob[g], bz);
      chk($sformatf("done%0d", WG), od[g], (ph == DG) ? 1 : 0);
      chk($sformatf("sel%0d", WG), {om1[g], om2[g], os[g]}, es);
      if (bz == 0) chk($sformatf("p%0d", WG), op[g], ep);
    end
  end
  task automatic run(input int g, input int aa, input int bb, input int tr, input int pe);
    int nd;
    nd = (g == 0) ? 3 : 5;
    @(negedge clk);
    st[g] = 1'b1;
    ia[g] = 8'(aa);
    ib[g] = 8'(bb);
    @(posedge clk);
    #1 st[g] = 1'b0;
    for (int d = 0; d < nd; d++) begin
      @(negedge clk);
      chk("hand_busy", ob[g], 1);
      if (tr >= 0) chk("hand_sel", {om1[g], om2[g], os[g]}, (tr >> (3 * (nd - 1 - d))) & 7);
      @(posedge clk);
    end
    @(negedge clk);
    chk("hand_done", od[g], 1);
    chk("hand_p", op[g], pe);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_p", op[0], 0);
    chk("rst_busy", ob[0], 0);
    reset_b = 1'b1;
    run(0, 15, 15, 9'b101_001_100, 225);
    run(0, 6, 11, 9'b011_010_000, 66);
    run(0, 0, 13, 9'b000_000_000, 0);
    @(negedge clk);
    st[0] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      ia[0] = 8'($urandom);
      ib[0] = 8'($urandom);
    end
    st[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    st[0] = 1'b1;
    ia[0] = 8'd5;
    ib[0] = 8'd5;
    @(posedge clk);
    #1 st[0] = 1'b0;
    @(posedge clk);
    #1 reset_b = 1'b0;
    #1;
    chk("abort_busy", ob[0], 0);
    chk("abort_sel", {om1[0], om2[0], os[0]}, 0);
    chk("abort_p", op[0], 0);
    chk("abort_done", od[0], 0);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (4) @(posedge clk);
    run(0, 9, 7, 9'b100_011_100, 63);
    run(1, 255, 255, -1, 65025);
    run(1, 128, 2, -1, 256);
    repeat (150) begin
      @(negedge clk);
      st[1] = 1'b1;
      ia[1] = 8'($urandom);
      ib[1] = 8'($urandom);
      @(posedge clk);
      #1 st[1] = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    st[1] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
